// File: rtl/semafor_pieton_param.sv
// Parametrised car + pedestrian traffic light driven from one system clock.
// A divider produces a one-cycle tick used as the phase timebase. The block
// also provides a synchronised request button, pedestrian blink warning,
// blinking-yellow night mode and a remaining-time readout.
module semafor_pieton_param #(
    parameter int unsigned TICK_DIV    = 12000000,
    parameter int unsigned GREEN_MIN   = 5,
    parameter int unsigned YELLOW_T    = 2,
    parameter int unsigned RED_T       = 3,
    parameter int unsigned PED_BLINK_T = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             buton,
    input  logic             mod_noapte,
    output logic             rosu,
    output logic             galben,
    output logic             verde,
    output logic             ped_rosu,
    output logic             ped_verde,
    output logic             buton_push,
    output logic             tick,
    output logic [CNT_W-1:0] count_semafor,
    output logic [7:0]       led
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2);

    localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] RED_C    = CNT_W'(RED_T);
    localparam logic [CNT_W-1:0] PBLINK_C = CNT_W'(PED_BLINK_T);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_RED    = 2'd2,
        ST_NIGHT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic             buton_push_q, buton_push_d;

    logic             btn_s1_q, btn_s1_d;
    logic             btn_s2_q, btn_s2_d;
    logic             btn_prev_q, btn_prev_d;
    logic             night_s1_q, night_s1_d;
    logic             night_s2_q, night_s2_d;

    logic             rosu_q, rosu_d;
    logic             galben_q, galben_d;
    logic             verde_q, verde_d;
    logic             ped_rosu_q, ped_rosu_d;
    logic             ped_verde_q, ped_verde_d;

    logic             blink_d;
    logic             press;
    logic             night_s;
    logic [CNT_W-1:0] sec_inc;

    // Tick divider: tick is registered but aligned with div_cnt == TICK_DIV-1.
    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DIV_W'(1);
        tick_d    = (div_cnt_d == DIV_MAX);
        blink_d   = (div_cnt_d < DIV_HALF);
    end

    // Two-flop synchronisers plus one history flop for button edge detection.
    always_comb begin
        btn_s1_d   = buton;
        btn_s2_d   = btn_s1_q;
        btn_prev_d = btn_s2_q;
        night_s1_d = mod_noapte;
        night_s2_d = night_s1_q;
        press      = btn_prev_q & ~btn_s2_q;
        night_s    = night_s2_q;
    end

    // Phase FSM, second counter and request latch next-state logic.
    always_comb begin
        state_d      = state_q;
        sec_cnt_d    = sec_cnt_q;
        buton_push_d = buton_push_q;
        sec_inc      = sec_cnt_q + ONE_C;

        case (state_q)
            ST_GREEN: begin
                if (tick_q) begin
                    if (night_s) begin
                        state_d = ST_NIGHT;
                    end else if ((sec_inc >= GREEN_C) && buton_push_q) begin
                        state_d = ST_YELLOW;
                    end else begin
                        sec_cnt_d = (sec_inc >= GREEN_C) ? GREEN_C : sec_inc;
                    end
                end
            end
            ST_YELLOW: begin
                if (tick_q) begin
                    if (sec_inc == YELLOW_C) state_d = ST_RED;
                    else                     sec_cnt_d = sec_inc;
                end
            end
            ST_RED: begin
                if (tick_q) begin
                    if (sec_inc == RED_C) state_d = night_s ? ST_NIGHT : ST_GREEN;
                    else                  sec_cnt_d = sec_inc;
                end
            end
            ST_NIGHT: begin
                if (tick_q) begin
                    if (!night_s) state_d = ST_YELLOW;
                    else          sec_cnt_d = sec_inc;
                end
            end
            default: begin
                state_d = ST_GREEN;
            end
        endcase

        if (state_d != state_q) begin
            sec_cnt_d = '0;
        end

        // Entering RED/NIGHT clears the request, overriding a same-cycle press.
        if ((state_d != state_q) && ((state_d == ST_RED) || (state_d == ST_NIGHT))) begin
            buton_push_d = 1'b0;
        end else if (press && ((state_q == ST_GREEN) || (state_q == ST_YELLOW))) begin
            buton_push_d = 1'b1;
        end
    end

    // Lamp values derived from the next state so they line up with state_q.
    always_comb begin
        rosu_d      = 1'b0;
        galben_d    = 1'b0;
        verde_d     = 1'b0;
        ped_rosu_d  = 1'b0;
        ped_verde_d = 1'b0;
        case (state_d)
            ST_GREEN: begin
                verde_d    = 1'b1;
                ped_rosu_d = 1'b1;
            end
            ST_YELLOW: begin
                galben_d   = 1'b1;
                ped_rosu_d = 1'b1;
            end
            ST_RED: begin
                rosu_d      = 1'b1;
                ped_verde_d = ((RED_C - sec_cnt_d) <= PBLINK_C) ? blink_d : 1'b1;
            end
            ST_NIGHT: begin
                galben_d = blink_d;
            end
            default: begin
                verde_d    = 1'b1;
                ped_rosu_d = 1'b1;
            end
        endcase
    end

    // All registered state, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_GREEN;
            div_cnt_q    <= '0;
            tick_q       <= 1'b0;
            sec_cnt_q    <= '0;
            buton_push_q <= 1'b0;
            btn_s1_q     <= 1'b1;
            btn_s2_q     <= 1'b1;
            btn_prev_q   <= 1'b1;
            night_s1_q   <= 1'b0;
            night_s2_q   <= 1'b0;
            rosu_q       <= 1'b0;
            galben_q     <= 1'b0;
            verde_q      <= 1'b1;
            ped_rosu_q   <= 1'b1;
            ped_verde_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            tick_q       <= tick_d;
            sec_cnt_q    <= sec_cnt_d;
            buton_push_q <= buton_push_d;
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            btn_prev_q   <= btn_prev_d;
            night_s1_q   <= night_s1_d;
            night_s2_q   <= night_s2_d;
            rosu_q       <= rosu_d;
            galben_q     <= galben_d;
            verde_q      <= verde_d;
            ped_rosu_q   <= ped_rosu_d;
            ped_verde_q  <= ped_verde_d;
        end
    end

    // Remaining-time readout from registered state.
    always_comb begin
        case (state_q)
            ST_GREEN:  count_semafor = GREEN_C - sec_cnt_q;
            ST_YELLOW: count_semafor = YELLOW_C - sec_cnt_q;
            ST_RED:    count_semafor = RED_C - sec_cnt_q;
            default:   count_semafor = '0;
        endcase
    end

    assign rosu       = rosu_q;
    assign galben     = galben_q;
    assign verde      = verde_q;
    assign ped_rosu   = ped_rosu_q;
    assign ped_verde  = ped_verde_q;
    assign buton_push = buton_push_q;
    assign tick       = tick_q;
    assign led        = ~{rosu_q, galben_q, verde_q, 2'b00, ped_verde_q, ped_rosu_q,
                          (state_q == ST_NIGHT)};

endmodule
